// File: rtl/pcie_phy_pkg.sv
// Shared Gen1 PHY definitions: 8b/10b control symbols, ordered-set identifiers
// and the state/field types used by the TX ordered-set scheduler.
package pcie_phy_pkg;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] SKP  = 8'h1C;
    localparam logic [7:0] PAD_ = 8'hF7;

    localparam logic [7:0] TS1_ID       = 8'h4A;
    localparam logic [7:0] TS2_ID       = 8'h45;
    localparam logic [7:0] GEN1_RATE_ID = 8'h02;

    // State literals carry an ST_ prefix so they cannot clash with the SKP symbol.
    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_SKP  = 2'd1,
        ST_TS   = 2'd2
    } os_state_e;

    typedef struct packed {
        logic       ts2;
        logic [7:0] link;
        logic [4:0] lane;
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] nfts;
        logic [7:0] ctrl;
    } ts_fields_t;

    function automatic logic [4:0] os_len(input os_state_e os_type);
        return (os_type == ST_TS) ? 5'd16 : 5'd4;
    endfunction

endpackage

// File: rtl/gen1_os_symbol.sv
// One byte lane of ordered-set symbol generation: maps OS type, symbol index
// and latched TS fields to a symbol byte plus its K flag.
module gen1_os_symbol
    import pcie_phy_pkg::*;
(
    input  logic [1:0] os_type_i,
    input  logic [3:0] sym_idx_i,
    input  logic       ts2_i,
    input  logic [7:0] link_i,
    input  logic [4:0] lane_i,
    input  logic       link_pad_i,
    input  logic       lane_pad_i,
    input  logic [7:0] nfts_i,
    input  logic [7:0] ctrl_i,
    output logic [7:0] sym_o,
    output logic       k_o
);

    always_comb begin
        sym_o = '0;
        k_o   = 1'b0;
        case (os_type_i)
            ST_SKP: begin
                k_o   = 1'b1;
                sym_o = (sym_idx_i == 4'd0) ? COM : SKP;
            end
            ST_TS: begin
                case (sym_idx_i)
                    4'd0: begin
                        sym_o = COM;
                        k_o   = 1'b1;
                    end
                    4'd1: begin
                        sym_o = link_pad_i ? PAD_ : link_i;
                        k_o   = link_pad_i;
                    end
                    4'd2: begin
                        sym_o = lane_pad_i ? PAD_ : {3'b000, lane_i};
                        k_o   = lane_pad_i;
                    end
                    4'd3:    sym_o = nfts_i;
                    4'd4:    sym_o = GEN1_RATE_ID;
                    4'd5:    sym_o = ctrl_i;
                    default: sym_o = ts2_i ? TS2_ID : TS1_ID;
                endcase
            end
            default: begin
                sym_o = '0;
                k_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/gen1_tx_os_scheduler.sv
// Gen1 TX ordered-set scheduler: merges link-layer beats, logical idle, TS1/TS2
// and periodic SKP ordered sets into one registered 32-bit symbol/K stream.
module gen1_tx_os_scheduler
    import pcie_phy_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  pipe_width_i,
    input  logic        tx_en_i,
    input  logic        ts_mode_i,
    input  logic        ts_type_i,
    input  logic [7:0]  ts_link_i,
    input  logic [4:0]  ts_lane_i,
    input  logic        ts_link_pad_i,
    input  logic        ts_lane_pad_i,
    input  logic [7:0]  ts_nfts_i,
    input  logic [7:0]  ts_ctrl_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  data_k_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    output logic        data_ready_o,
    output logic [31:0] data_o,
    output logic [3:0]  data_k_o,
    output logic        data_valid_o,
    output logic        ts_sent_o,
    output logic        skp_sent_o
);

    os_state_e        state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skp_pending_q, skp_pending_d;
    logic             in_packet_q, in_packet_d;
    logic [2:0]       bpb_q, bpb_d;
    ts_fields_t       ts_q, ts_d;

    logic [31:0]      data_q, data_d;
    logic [3:0]       k_q, k_d;
    logic             valid_q, valid_d;
    logic             ts_sent_q, ts_sent_d;
    logic             skp_sent_q, skp_sent_d;

    logic [2:0]       bpb_live, bpb_cur;
    ts_fields_t       ts_live, ts_sel;
    os_state_e        os_type;
    logic [3:0]       sym_base;
    logic             os_start;
    logic             accept;
    logic             ready_int;
    logic [CNT_W:0]   cnt_sum;
    logic [4:0]       sym_next;

    logic [7:0]       lane_sym [4];
    logic [3:0]       lane_k;

    // Decide what this cycle emits: an accepted beat, idle, or the next OS beat.
    // In DATA an OS start emits its first beat in the same cycle.
    always_comb begin
        bpb_live  = pipe_width_i[5:3];
        bpb_cur   = (state_q == ST_DATA) ? bpb_live : bpb_q;
        ts_live   = '{ts2:      ts_type_i,
                      link:     ts_link_i,
                      lane:     ts_lane_i,
                      link_pad: ts_link_pad_i,
                      lane_pad: ts_lane_pad_i,
                      nfts:     ts_nfts_i,
                      ctrl:     ts_ctrl_i};
        os_type   = ST_DATA;
        sym_base  = '0;
        os_start  = 1'b0;
        accept    = 1'b0;
        ready_int = 1'b0;
        if (tx_en_i) begin
            case (state_q)
                ST_DATA: begin
                    if (ts_mode_i) begin
                        os_start = 1'b1;
                        os_type  = skp_pending_q ? ST_SKP : ST_TS;
                    end else if (skp_pending_q && !in_packet_q) begin
                        os_start = 1'b1;
                        os_type  = ST_SKP;
                    end else begin
                        ready_int = 1'b1;
                        accept    = data_valid_i;
                    end
                end
                default: begin
                    os_type  = state_q;
                    sym_base = idx_q;
                end
            endcase
        end
        ts_sel = os_start ? ts_live : ts_q;
    end

    assign data_ready_o = rst_ni && ready_int;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        gen1_os_symbol u_sym (
            .os_type_i  (os_type),
            .sym_idx_i  (sym_base + 4'(g)),
            .ts2_i      (ts_sel.ts2),
            .link_i     (ts_sel.link),
            .lane_i     (ts_sel.lane),
            .link_pad_i (ts_sel.link_pad),
            .lane_pad_i (ts_sel.lane_pad),
            .nfts_i     (ts_sel.nfts),
            .ctrl_i     (ts_sel.ctrl),
            .sym_o      (lane_sym[g]),
            .k_o        (lane_k[g])
        );
    end

    // Next-state: SKP counter, packet tracking, OS sequencing and the output beat.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        skp_pending_d = skp_pending_q;
        in_packet_d   = in_packet_q;
        bpb_d         = bpb_q;
        ts_d          = ts_q;
        data_d        = '0;
        k_d           = '0;
        valid_d       = tx_en_i;
        ts_sent_d     = 1'b0;
        skp_sent_d    = 1'b0;
        cnt_sum       = {1'b0, cnt_q} + (CNT_W+1)'(bpb_cur);
        sym_next      = {1'b0, sym_base} + {2'b00, bpb_cur};
        if (tx_en_i) begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            if (cnt_sum >= (CNT_W+1)'(SKP_INTERVAL)) begin
                skp_pending_d = 1'b1;
            end
            if (state_q == ST_DATA && ts_mode_i) begin
                in_packet_d = 1'b0;
            end
            if (accept) begin
                in_packet_d = !data_last_i;
            end
            for (int l = 0; l < 4; l++) begin
                if (3'(l) < bpb_cur) begin
                    if (accept) begin
                        data_d[8*l +: 8] = data_i[8*l +: 8];
                        k_d[l]           = data_k_i[l];
                    end else if (os_type != ST_DATA) begin
                        data_d[8*l +: 8] = lane_sym[l];
                        k_d[l]           = lane_k[l];
                    end
                end
            end
            if (os_start) begin
                bpb_d = bpb_live;
                ts_d  = ts_live;
            end
            if (os_type == ST_SKP && sym_base == 4'd0) begin
                cnt_d         = '0;
                skp_pending_d = 1'b0;
            end
            if (os_type != ST_DATA) begin
                if (sym_next >= os_len(os_type)) begin
                    state_d    = ST_DATA;
                    idx_d      = '0;
                    ts_sent_d  = (os_type == ST_TS);
                    skp_sent_d = (os_type == ST_SKP);
                end else begin
                    state_d = os_type;
                    idx_d   = sym_next[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_DATA;
            idx_q         <= '0;
            cnt_q         <= '0;
            skp_pending_q <= 1'b0;
            in_packet_q   <= 1'b0;
            bpb_q         <= '0;
            ts_q          <= '0;
            data_q        <= '0;
            k_q           <= '0;
            valid_q       <= 1'b0;
            ts_sent_q     <= 1'b0;
            skp_sent_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            skp_pending_q <= skp_pending_d;
            in_packet_q   <= in_packet_d;
            bpb_q         <= bpb_d;
            ts_q          <= ts_d;
            data_q        <= data_d;
            k_q           <= k_d;
            valid_q       <= valid_d;
            ts_sent_q     <= ts_sent_d;
            skp_sent_q    <= skp_sent_d;
        end
    end

    assign data_o       = data_q;
    assign data_k_o     = k_q;
    assign data_valid_o = valid_q;
    assign ts_sent_o    = ts_sent_q;
    assign skp_sent_o   = skp_sent_q;

    // Only 8/16/32-bit PIPE widths are meaningful.
    pipe_width_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        tx_en_i |-> (pipe_width_i == 6'd8 || pipe_width_i == 6'd16 || pipe_width_i == 6'd32));

endmodule

// File: tb/tb_gen1_tx_os_scheduler.sv
// Directed self-checking bench for gen1_tx_os_scheduler: TS1/TS2 framing,
// SKP insertion timing, packet boundaries, reset and tx_en freezing.
module tb_gen1_tx_os_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [5:0]  pipeWidth;
    logic        txEn;
    logic        tsMode;
    logic        tsType;
    logic [7:0]  tsLink;
    logic [4:0]  tsLane;
    logic        linkPad;
    logic        lanePad;
    logic [7:0]  tsNfts;
    logic [7:0]  tsCtrl;
    logic [31:0] dataIn;
    logic [3:0]  dataKIn;
    logic        dataValid;
    logic        dataLast;
    logic        data_ready_o;
    logic [31:0] data_o;
    logic [3:0]  data_k_o;
    logic        data_valid_o;
    logic        ts_sent_o;
    logic        skp_sent_o;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk_i = ~clk_i;

    gen1_tx_os_scheduler #(
        .SKP_INTERVAL (1180),
        .CNT_W        (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pipe_width_i  (pipeWidth),
        .tx_en_i       (txEn),
        .ts_mode_i     (tsMode),
        .ts_type_i     (tsType),
        .ts_link_i     (tsLink),
        .ts_lane_i     (tsLane),
        .ts_link_pad_i (linkPad),
        .ts_lane_pad_i (lanePad),
        .ts_nfts_i     (tsNfts),
        .ts_ctrl_i     (tsCtrl),
        .data_i        (dataIn),
        .data_k_i      (dataKIn),
        .data_valid_i  (dataValid),
        .data_last_i   (dataLast),
        .data_ready_o  (data_ready_o),
        .data_o        (data_o),
        .data_k_o      (data_k_o),
        .data_valid_o  (data_valid_o),
        .ts_sent_o     (ts_sent_o),
        .skp_sent_o    (skp_sent_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] width, input logic en, input logic mode);
        pipeWidth = width;
        txEn      = en;
        tsMode    = mode;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic resetDut();
        rst_ni = 1'b0;
        repeat (2) tick();
        #3;
        rst_ni = 1'b1;
    endtask

    function automatic logic [31:0] beatVal(input int i);
        return {16'h0000, 8'(i + 1), 8'h5A};
    endfunction

    logic [31:0] expTs4 [4];
    logic [7:0]  expTs2 [16];
    logic [31:0] outData [23];
    logic [3:0]  outK [23];
    logic        outSkp [23];
    logic        readyLog [23];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beat;
        int firstSkp;
        int pktIdx;
        int outIdx;
        logic accepted;

        rst_ni    = 1'b0;
        applyStimulus(6'd32, 1'b1, 1'b1);
        tsType    = 1'b0;
        tsLink    = 8'h01;
        tsLane    = 5'd3;
        linkPad   = 1'b0;
        lanePad   = 1'b0;
        tsNfts    = 8'h10;
        tsCtrl    = 8'h00;
        dataIn    = '0;
        dataKIn   = '0;
        dataValid = 1'b0;
        dataLast  = 1'b0;

        // Reset state with the clock running and inputs active.
        repeat (2) tick();
        checkOutput("rst_data", data_o, 32'h0);
        checkOutput("rst_k", {28'h0, data_k_o}, 32'h0);
        checkOutput("rst_valid", {31'h0, data_valid_o}, 32'h0);
        checkOutput("rst_ready", {31'h0, data_ready_o}, 32'h0);
        checkOutput("rst_ts_sent", {31'h0, ts_sent_o}, 32'h0);
        checkOutput("rst_skp_sent", {31'h0, skp_sent_o}, 32'h0);

        // TS1 at 4 bytes per beat, followed back-to-back by another TS.
        expTs4[0] = 32'h100301BC;
        expTs4[1] = 32'h4A4A0002;
        expTs4[2] = 32'h4A4A4A4A;
        expTs4[3] = 32'h4A4A4A4A;
        #3;
        rst_ni = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            checkOutput($sformatf("ts1_w4_data%0d", b), data_o, expTs4[b]);
            checkOutput($sformatf("ts1_w4_k%0d", b), {28'h0, data_k_o}, (b == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("ts1_w4_sent%0d", b), {31'h0, ts_sent_o}, (b == 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("ts1_w4_valid%0d", b), {31'h0, data_valid_o}, 32'h1);
        end
        tick();
        checkOutput("ts1_b2b_com", data_o, 32'h100301BC);
        tick();
        checkOutput("ts1_b2b_beat1", data_o, 32'h4A4A0002);

        // Asynchronous reset in the middle of a TS, then restart at symbol 0.
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_data", data_o, 32'h0);
        checkOutput("async_rst_k", {28'h0, data_k_o}, 32'h0);
        checkOutput("async_rst_valid", {31'h0, data_valid_o}, 32'h0);
        checkOutput("async_rst_ready", {31'h0, data_ready_o}, 32'h0);
        repeat (2) tick();
        #3;
        rst_ni = 1'b1;
        tick();
        checkOutput("rst_restart_com", data_o, 32'h100301BC);
        checkOutput("rst_restart_k", {28'h0, data_k_o}, 32'h1);

        // TS2 at 1 byte per beat with link and lane both padded.
        applyStimulus(6'd8, 1'b1, 1'b1);
        tsType  = 1'b1;
        tsLink  = 8'h55;
        tsLane  = 5'd7;
        linkPad = 1'b1;
        lanePad = 1'b1;
        tsNfts  = 8'h22;
        tsCtrl  = 8'h05;
        expTs2[0] = 8'hBC;
        expTs2[1] = 8'hF7;
        expTs2[2] = 8'hF7;
        expTs2[3] = 8'h22;
        expTs2[4] = 8'h02;
        expTs2[5] = 8'h05;
        for (int s = 6; s < 16; s++) expTs2[s] = 8'h45;
        resetDut();
        for (int b = 0; b < 16; b++) begin
            tick();
            checkOutput($sformatf("ts2_w1_data%0d", b), data_o, {24'h0, expTs2[b]});
            checkOutput($sformatf("ts2_w1_k%0d", b), {28'h0, data_k_o}, (b < 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("ts2_w1_sent%0d", b), {31'h0, ts_sent_o}, (b == 15) ? 32'h1 : 32'h0);
        end

        // SKP insertion into logical idle at 4 bytes per beat.
        applyStimulus(6'd32, 1'b1, 1'b0);
        dataValid = 1'b0;
        resetDut();
        beat = 0;
        firstSkp = 0;
        for (int c = 0; c < 400 && firstSkp == 0; c++) begin
            tick();
            beat++;
            if (data_o != 32'h0 || data_k_o != 4'h0) firstSkp = beat;
        end
        checkOutput("skp_w4_beat", 32'(firstSkp), 32'd296);
        checkOutput("skp_w4_data", data_o, 32'h1C1C1CBC);
        checkOutput("skp_w4_k", {28'h0, data_k_o}, 32'hF);
        checkOutput("skp_w4_sent", {31'h0, skp_sent_o}, 32'h1);
        tick();
        checkOutput("skp_w4_idle_data", data_o, 32'h0);
        checkOutput("skp_w4_idle_sent", {31'h0, skp_sent_o}, 32'h0);
        checkOutput("skp_w4_idle_valid", {31'h0, data_valid_o}, 32'h1);

        // 20-beat packet at 2 bytes per beat straddling SKP expiry (cycle 589).
        applyStimulus(6'd16, 1'b1, 1'b0);
        resetDut();
        repeat (580) tick();
        pktIdx = 0;
        outIdx = 0;
        for (int c = 0; c < 40 && outIdx < 23; c++) begin
            dataValid = 1'b1;
            dataIn    = beatVal(pktIdx);
            dataKIn   = 4'h0;
            dataLast  = (pktIdx == 19);
            #1;
            accepted = dataValid && data_ready_o;
            readyLog[outIdx] = data_ready_o;
            tick();
            if (accepted) pktIdx++;
            outData[outIdx] = data_o;
            outK[outIdx]    = data_k_o;
            outSkp[outIdx]  = skp_sent_o;
            outIdx++;
        end
        dataValid = 1'b0;
        dataLast  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("pkt_beat%0d", i), outData[i], beatVal(i));
        end
        checkOutput("pkt_skp0_data", outData[20], 32'h00001CBC);
        checkOutput("pkt_skp0_k", {28'h0, outK[20]}, 32'h3);
        checkOutput("pkt_skp0_sent", {31'h0, outSkp[20]}, 32'h0);
        checkOutput("pkt_skp1_data", outData[21], 32'h00001C1C);
        checkOutput("pkt_skp1_k", {28'h0, outK[21]}, 32'h3);
        checkOutput("pkt_skp1_sent", {31'h0, outSkp[21]}, 32'h1);
        checkOutput("pkt_next_beat", outData[22], beatVal(20));
        checkOutput("pkt_ready_last", {31'h0, readyLog[19]}, 32'h1);
        checkOutput("pkt_ready_skp0", {31'h0, readyLog[20]}, 32'h0);
        checkOutput("pkt_ready_skp1", {31'h0, readyLog[21]}, 32'h0);
        checkOutput("pkt_ready_after", {31'h0, readyLog[22]}, 32'h1);
        checkOutput("pkt_accepted", 32'(pktIdx), 32'd21);

        // ts_mode 0->1 in the middle of a packet at 4 bytes per beat.
        applyStimulus(6'd32, 1'b1, 1'b0);
        tsType  = 1'b0;
        tsLink  = 8'h01;
        tsLane  = 5'd3;
        linkPad = 1'b0;
        lanePad = 1'b0;
        tsNfts  = 8'h10;
        tsCtrl  = 8'h00;
        resetDut();
        for (int i = 0; i < 3; i++) begin
            dataValid = 1'b1;
            dataIn    = 32'hC0DE0000 | 32'(i);
            dataLast  = 1'b0;
            tick();
        end
        checkOutput("mode_pkt_beat2", data_o, 32'hC0DE0002);
        dataIn = 32'hC0DE0003;
        tsMode = 1'b1;
        #1;
        checkOutput("mode_switch_ready", {31'h0, data_ready_o}, 32'h0);
        tick();
        checkOutput("mode_switch_com", data_o, 32'h100301BC);
        checkOutput("mode_switch_k", {28'h0, data_k_o}, 32'h1);
        tsMode = 1'b0;
        repeat (3) tick();
        checkOutput("mode_ts_last", data_o, 32'h4A4A4A4A);
        checkOutput("mode_ts_sent", {31'h0, ts_sent_o}, 32'h1);
        #1;
        checkOutput("post_ts_ready", {31'h0, data_ready_o}, 32'h1);
        tick();
        checkOutput("post_ts_data", data_o, 32'hC0DE0003);
        dataValid = 1'b0;

        // tx_en dropped for 10 cycles in the middle of a 1-byte-per-beat SKP.
        applyStimulus(6'd8, 1'b1, 1'b0);
        resetDut();
        beat = 0;
        firstSkp = 0;
        for (int c = 0; c < 1300 && firstSkp == 0; c++) begin
            tick();
            beat++;
            if (data_o != 32'h0 || data_k_o != 4'h0) firstSkp = beat;
        end
        checkOutput("skp_w1_beat", 32'(firstSkp), 32'd1181);
        checkOutput("skp_w1_com", data_o, 32'h000000BC);
        applyStimulus(6'd8, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput($sformatf("txen_off_valid%0d", c), {31'h0, data_valid_o}, 32'h0);
        end
        checkOutput("txen_off_data", data_o, 32'h0);
        checkOutput("txen_off_ready", {31'h0, data_ready_o}, 32'h0);
        applyStimulus(6'd8, 1'b1, 1'b0);
        for (int s = 1; s < 4; s++) begin
            tick();
            checkOutput($sformatf("skp_resume_data%0d", s), data_o, 32'h0000001C);
            checkOutput($sformatf("skp_resume_k%0d", s), {28'h0, data_k_o}, 32'h1);
            checkOutput($sformatf("skp_resume_sent%0d", s), {31'h0, skp_sent_o}, (s == 3) ? 32'h1 : 32'h0);
        end
        tick();
        checkOutput("skp_resume_idle", data_o, 32'h0);
        checkOutput("skp_resume_valid", {31'h0, data_valid_o}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
